// File: rtl/rotate_phase_ctrl.sv
// Frame sequencer for the rotate datapath: streams I/Q samples with a wrapped per-sample
// phase, then issues zero flush strobes to drain rotate before pulsing done.
module rotate_phase_ctrl #(
  parameter int OPI          = 1608,
  parameter int FLUSH_CYCLES = 8
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [15:0] cfg_freq,
  input  logic [15:0] cfg_phase0,
  input  logic [15:0] cfg_len,
  input  logic        abort,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [15:0] s_i,
  input  logic [15:0] s_q,
  output logic        rot_ivalid,
  output logic [15:0] rot_phase,
  output logic [15:0] rot_i,
  output logic [15:0] rot_q,
  output logic        busy,
  output logic        done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;

  localparam logic signed [16:0] OPI_S     = 17'(OPI);
  localparam logic signed [16:0] TWO_OPI_S = 17'(2 * OPI);
  localparam logic [7:0]         FLUSH_N   = 8'(FLUSH_CYCLES);

  logic [1:0]         state;
  logic [15:0]        freq;
  logic [15:0]        acc;
  logic [15:0]        remaining;
  logic [7:0]         flush_cnt;
  logic               accept;
  logic signed [16:0] sum;
  logic signed [16:0] wrapped;

  assign cfg_ready = (state == IDLE);
  assign s_ready   = (state == RUN);
  assign busy      = (state != IDLE);
  // abort wins over a sample offered in the same cycle.
  assign accept    = s_ready & s_valid & ~abort;

  // One correction is enough because |freq| < OPI keeps the sum within (-3*OPI, 3*OPI).
  always_comb begin
    sum     = $signed({acc[15], acc}) + $signed({freq[15], freq});
    wrapped = sum;
    if (sum >= OPI_S)
      wrapped = sum - TWO_OPI_S;
    else if (sum < -OPI_S)
      wrapped = sum + TWO_OPI_S;
  end

  // NOTE: all state here is registered with non-blocking assignments so every branch
  // sees the pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      freq       <= '0;
      acc        <= '0;
      remaining  <= '0;
      flush_cnt  <= '0;
      rot_ivalid <= 1'b0;
      rot_phase  <= '0;
      rot_i      <= '0;
      rot_q      <= '0;
      done       <= 1'b0;
    end else begin
      rot_ivalid <= 1'b0;
      done       <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_valid && (cfg_len != 16'd0)) begin
            freq      <= cfg_freq;
            acc       <= cfg_phase0;
            remaining <= cfg_len;
            state     <= RUN;
          end
        end
        RUN: begin
          if (abort) begin
            state     <= FLUSH;
            flush_cnt <= FLUSH_N;
          end else if (accept) begin
            rot_ivalid <= 1'b1;
            rot_phase  <= acc;
            rot_i      <= s_i;
            rot_q      <= s_q;
            acc        <= wrapped[15:0];
            remaining  <= remaining - 16'd1;
            if (remaining == 16'd1) begin
              state     <= FLUSH;
              flush_cnt <= FLUSH_N;
            end
          end
        end
        FLUSH: begin
          if (flush_cnt != 8'd0) begin
            rot_ivalid <= 1'b1;
            rot_phase  <= '0;
            rot_i      <= '0;
            rot_q      <= '0;
            flush_cnt  <= flush_cnt - 8'd1;
          end else begin
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rotate_phase_ctrl.sv
// Self-checking bench for rotate_phase_ctrl: table of frame vectors plus random frames,
// compared cycle by cycle against a modulo-arithmetic phase model.
module tb_rotate_phase_ctrl;

  localparam int OPI   = 1608;
  localparam int FLUSH = 8;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [15:0] cfg_freq;
  logic [15:0] cfg_phase0;
  logic [15:0] cfg_len;
  logic        abort;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] s_i;
  logic [15:0] s_q;
  logic        rot_ivalid;
  logic [15:0] rot_phase;
  logic [15:0] rot_i;
  logic [15:0] rot_q;
  logic        busy;
  logic        done;

  rotate_phase_ctrl #(.OPI(OPI), .FLUSH_CYCLES(FLUSH)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_freq   (cfg_freq),
    .cfg_phase0 (cfg_phase0),
    .cfg_len    (cfg_len),
    .abort      (abort),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_i        (s_i),
    .s_q        (s_q),
    .rot_ivalid (rot_ivalid),
    .rot_phase  (rot_phase),
    .rot_i      (rot_i),
    .rot_q      (rot_q),
    .busy       (busy),
    .done       (done)
  );

  always #5 clock = ~clock;

  typedef struct {
    int f;
    int p0;
    int len;
    int mode;      // 0: s_valid held, 1: toggling, 2: random
    int abort_at;  // abort offered after this many accepts, -1 none
    int reset_at;  // async reset after this many accepts, -1 none
    bit poke;      // offer junk configs during RUN
    int n_exp;
    int exp_ph[6];
    int exp_cnt;   // expected sample strobes, -1 unchecked
  } vec_t;

  int total = 0;
  int bad   = 0;
  int obs_ph[$];
  logic [15:0] hp, hi, hq;  // values rot_* must hold in idle cycles

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step_check(input string nm, input logic iv, input logic [15:0] ph,
                            input logic [15:0] ii, input logic [15:0] qq, input logic dn,
                            input logic bz, input logic sr, input logic cr);
    check(nm, 64'({rot_ivalid, rot_phase, rot_i, rot_q, done, busy, s_ready, cfg_ready}),
          64'({iv, ph, ii, qq, dn, bz, sr, cr}));
  endtask

  // Phase of sample k: phase0 + k*freq folded into [-OPI, OPI).
  function automatic int model_phase(input int p0, input int f, input int k);
    longint v;
    v = longint'(p0) + longint'(f) * longint'(k) + longint'(OPI);
    v = v % longint'(2 * OPI);
    if (v < 0) v = v + longint'(2 * OPI);
    return int'(v - longint'(OPI));
  endfunction

  task automatic run_frame(input int idx, input vec_t v);
    int  k = 0;
    int  iter = 0;
    bit  ab_done = 1'b0;
    bit  sv, ab, acc, run;
    logic [15:0] ei, eq;
    obs_ph.delete();
    cfg_valid  = 1'b1;
    cfg_freq   = 16'(v.f);
    cfg_phase0 = 16'(v.p0);
    cfg_len    = 16'(v.len);
    @(posedge clock); #1;
    cfg_valid  = 1'b0;
    cfg_freq   = 16'($urandom);
    cfg_phase0 = 16'($urandom);
    cfg_len    = 16'($urandom);
    step_check($sformatf("v%0d cfg", idx), 1'b0, hp, hi, hq, 1'b0, 1'b1, 1'b1, 1'b0);
    while (k < v.len && !ab_done && iter < 2000) begin
      iter++;
      if (k == v.reset_at) begin
        s_valid = 1'b1;
        #2 reset_n = 1'b0;
        #1 step_check($sformatf("v%0d async rst", idx), 1'b0, 16'd0, 16'd0, 16'd0,
                      1'b0, 1'b0, 1'b0, 1'b1);
        @(posedge clock); #1;
        step_check($sformatf("v%0d rst hold", idx), 1'b0, 16'd0, 16'd0, 16'd0,
                   1'b0, 1'b0, 1'b0, 1'b1);
        s_valid = 1'b0;
        @(negedge clock) reset_n = 1'b1;
        @(posedge clock); #1;
        step_check($sformatf("v%0d rst idle", idx), 1'b0, 16'd0, 16'd0, 16'd0,
                   1'b0, 1'b0, 1'b0, 1'b1);
        hp = '0; hi = '0; hq = '0;
        return;
      end
      case (v.mode)
        0:       sv = 1'b1;
        1:       sv = (iter % 2) == 1;
        default: sv = 1'($urandom_range(0, 1));
      endcase
      ab = (k == v.abort_at);
      if (ab) sv = 1'b1;
      s_valid = sv;
      s_i     = 16'($urandom);
      s_q     = 16'($urandom);
      abort   = ab;
      if (v.poke) begin
        cfg_valid  = 1'b1;
        cfg_len    = 16'($urandom_range(1, 50));
        cfg_phase0 = 16'($urandom_range(0, 1000));
        cfg_freq   = 16'($urandom_range(0, 1000));
      end
      ei  = s_i;
      eq  = s_q;
      acc = sv && !ab;
      @(posedge clock); #1;
      s_valid   = 1'b0;
      abort     = 1'b0;
      cfg_valid = 1'b0;
      if (acc) begin
        hp = 16'(model_phase(v.p0, v.f, k));
        hi = ei;
        hq = eq;
        k++;
      end
      if (ab) ab_done = 1'b1;
      if (rot_ivalid) obs_ph.push_back(int'($signed(rot_phase)));
      run = !(ab_done || k == v.len);
      step_check($sformatf("v%0d run it%0d", idx, iter), acc, hp, hi, hq, 1'b0, 1'b1, run, 1'b0);
    end
    if (iter >= 2000) check($sformatf("v%0d frame timeout", idx), 64'd1, 64'd0);
    if (v.exp_cnt >= 0)
      check($sformatf("v%0d strobe count", idx), 64'(obs_ph.size()), 64'(v.exp_cnt));
    for (int j = 0; j < FLUSH; j++) begin
      s_valid = 1'b1;
      s_i     = 16'($urandom);
      s_q     = 16'($urandom);
      abort   = 1'($urandom_range(0, 1));
      @(posedge clock); #1;
      step_check($sformatf("v%0d flush %0d", idx, j), 1'b1, 16'd0, 16'd0, 16'd0,
                 1'b0, 1'b1, 1'b0, 1'b0);
    end
    s_valid = 1'b0;
    abort   = 1'b0;
    hp = '0; hi = '0; hq = '0;
    @(posedge clock); #1;
    step_check($sformatf("v%0d done", idx), 1'b0, 16'd0, 16'd0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    @(posedge clock); #1;
    step_check($sformatf("v%0d after done", idx), 1'b0, 16'd0, 16'd0, 16'd0,
               1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < v.n_exp; i++) begin
      if (i < obs_ph.size())
        check($sformatf("v%0d phase[%0d]", idx, i), 64'(obs_ph[i]), 64'(v.exp_ph[i]));
      else
        check($sformatf("v%0d phase[%0d] missing", idx, i), 64'd1, 64'd0);
    end
  endtask

  initial begin
    vec_t tbl[9];
    vec_t rv;
    tbl[0] = '{1000, 0, 5, 0, -1, -1, 1'b0, 5, '{0, 1000, -1216, -216, 784, 0}, 5};
    tbl[1] = '{-700, -1000, 3, 0, -1, -1, 1'b0, 3, '{-1000, 1516, 816, 0, 0, 0}, 3};
    tbl[2] = '{1500, 1500, 4, 1, -1, -1, 1'b0, 4, '{1500, -216, 1284, -432, 0, 0}, 4};
    tbl[3] = '{1607, -1608, 6, 2, -1, -1, 1'b0, 6, '{-1608, -1, 1606, -3, 1604, -5}, 6};
    tbl[4] = '{-1607, 1607, 4, 0, -1, -1, 1'b0, 4, '{1607, 0, -1607, 2, 0, 0}, 4};
    tbl[5] = '{37, 100, 100, 0, 10, -1, 1'b0, 2, '{100, 137, 0, 0, 0, 0}, 10};
    tbl[6] = '{-300, 1600, 7, 2, -1, -1, 1'b1, 3, '{1600, 1300, 1000, 0, 0, 0}, 7};
    tbl[7] = '{500, 200, 20, 0, -1, 3, 1'b0, 0, '{0, 0, 0, 0, 0, 0}, -1};
    tbl[8] = '{250, -1500, 3, 0, -1, -1, 1'b0, 3, '{-1500, -1250, -1000, 0, 0, 0}, 3};

    reset_n = 1'b0; cfg_valid = 1'b0; cfg_freq = '0; cfg_phase0 = '0; cfg_len = '0;
    abort = 1'b0; s_valid = 1'b0; s_i = '0; s_q = '0;
    hp = '0; hi = '0; hq = '0;
    repeat (2) @(posedge clock);
    #1 step_check("reset", 1'b0, 16'd0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clock) reset_n = 1'b1;

    // Zero-length configs and idle aborts must leave the block idle.
    cfg_valid = 1'b1; cfg_len = 16'd0; cfg_freq = 16'd5; cfg_phase0 = 16'd5; abort = 1'b1;
    s_valid = 1'b1;
    for (int j = 0; j < 2; j++) begin
      @(posedge clock); #1;
      step_check($sformatf("len0 %0d", j), 1'b0, 16'd0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    cfg_valid = 1'b0; abort = 1'b0; s_valid = 1'b0;

    for (int t = 0; t < 9; t++) run_frame(t, tbl[t]);

    for (int r = 0; r < 6; r++) begin
      rv = '{default: 0};
      rv.f        = int'($urandom_range(0, 3214)) - 1607;
      rv.p0       = int'($urandom_range(0, 3215)) - 1608;
      rv.len      = int'($urandom_range(1, 20));
      rv.mode     = 2;
      rv.abort_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, rv.len - 1)) : -1;
      rv.reset_at = -1;
      rv.poke     = 1'($urandom_range(0, 1));
      rv.n_exp    = 0;
      rv.exp_cnt  = (rv.abort_at >= 0) ? rv.abort_at : rv.len;
      run_frame(100 + r, rv);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
